// File: rtl/dr_pkg.sv
// rtl/dr_pkg.sv - shared encodings for the window scheduler: read select, lane command, FSM state
package dr_pkg;

  typedef enum logic [1:0] {
    RPSEL_RR = 2'd0,
    RPSEL_BR = 2'd1,
    RPSEL_RP = 2'd2,
    RPSEL_NE = 2'd3
  } rpsel_e;

  typedef enum logic [1:0] {
    CMD_IB = 2'd0,
    CMD_SF = 2'd1,
    CMD_IF = 2'd2,
    CMD_NE = 2'd3
  } reg_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT_RD = 3'd1,
    ST_INIT_WT = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_NTRAN   = 3'd4,
    ST_FLUSH   = 3'd5
  } wsched_state_e;

endpackage

// File: rtl/wsched_pulse_gen.sv
// rtl/wsched_pulse_gen.sv - DWPE enable decode and line-FIFO pop delay line for window_sched
module wsched_pulse_gen
  import dr_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  wsched_state_e state,
  input  logic          pw_mode,
  output logic          pe_ena,
  output logic          fifo_read
);

  wsched_state_e prev_state;
  logic          shift_exit;
  logic          exit_d1;

  // The line FIFO pops two cycles after the FSM leaves a SHIFT window.
  assign shift_exit = (prev_state == ST_SHIFT) && (state != ST_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state <= ST_IDLE;
      exit_d1    <= 1'b0;
      fifo_read  <= 1'b0;
    end else begin
      prev_state <= state;
      exit_d1    <= shift_exit;
      fifo_read  <= exit_d1;
    end
  end

  assign pe_ena = (state == ST_SHIFT) || (state == ST_FLUSH) ||
                  ((state == ST_INIT_WT) && pw_mode);

endmodule

// File: rtl/window_sched.sv
// rtl/window_sched.sv - DWPE window scheduler: buffer reads, lane commands, tile control
// Defining WSCHED_PW_EN adds cfg_pw (pointwise, ksize=1, SHIFT bypassed).
module window_sched
  import dr_pkg::*;
#(
  parameter int POY       = 3,
  parameter int KSIZE_MAX = 5,
  parameter int COL_W     = 28,
  parameter int ROW_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         cfg_ksize,
  input  logic [1:0]         cfg_stride,
  input  logic [ROW_W-1:0]   cfg_nrow,
`ifdef WSCHED_PW_EN
  input  logic               cfg_pw,
`endif
  output logic               rd_req,
  input  logic               rd_gnt,
  output logic [1:0]         rpsel,
  output logic [1:0]         bank,
  output logic [ROW_W-1:0]   row,
  output logic [COL_W-1:0]   col,
  output logic [2*POY-1:0]   reg_cmd,
  output logic               fifo_read,
  output logic               pe_ena,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [1:0] BANK_LAST = 2'(POY - 1);

  function automatic logic [2*POY-1:0] lanes_all(input reg_cmd_e c);
    logic [2*POY-1:0] v;
    for (int i = 0; i < POY; i++) v[2*i +: 2] = c;
    return v;
  endfunction

  // Top lane takes fresh buffer data while the rest inherit from the lane above.
  function automatic logic [2*POY-1:0] lanes_ntran();
    logic [2*POY-1:0] v;
    v = lanes_all(CMD_IF);
    v[2*(POY-1) +: 2] = CMD_IB;
    return v;
  endfunction

  wsched_state_e    state;
  logic [2:0]       ksize_q;
  logic [1:0]       stride_q;
  logic [ROW_W-1:0] nrow_q;
  logic             pw_q;
  logic [1:0]       init_cnt;
  logic [ROW_W-1:0] grp_cnt;
  logic [2:0]       shift_cnt;

  logic             pw_sel;
  logic [2:0]       ksize_min;
  logic             cfg_legal;
  logic             shift_last;
  logic [ROW_W:0]   grp_next;
  logic             grp_more;

`ifdef WSCHED_PW_EN
  assign pw_sel = cfg_pw;
`else
  assign pw_sel = 1'b0;
`endif

  assign ksize_min  = pw_sel ? 3'd1 : 3'd2;
  assign cfg_legal  = (cfg_ksize >= ksize_min) && (int'(cfg_ksize) <= KSIZE_MAX) &&
                      (cfg_stride != 2'd0) && (int'(cfg_stride) <= POY) &&
                      (cfg_nrow != '0);
  assign shift_last = (shift_cnt + 3'd2) == ksize_q;
  assign grp_next   = {1'b0, grp_cnt} + (ROW_W+1)'(1);
  assign grp_more   = grp_next < {1'b0, nrow_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ksize_q   <= '0;
      stride_q  <= '0;
      nrow_q    <= '0;
      pw_q      <= 1'b0;
      init_cnt  <= '0;
      grp_cnt   <= '0;
      shift_cnt <= '0;
      rd_req    <= 1'b0;
      rpsel     <= RPSEL_NE;
      reg_cmd   <= lanes_all(CMD_NE);
      bank      <= BANK_LAST;
      row       <= '0;
      col       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_legal) begin
              ksize_q   <= cfg_ksize;
              stride_q  <= cfg_stride;
              nrow_q    <= cfg_nrow;
              pw_q      <= pw_sel;
              init_cnt  <= '0;
              grp_cnt   <= '0;
              shift_cnt <= '0;
              bank      <= BANK_LAST;
              row       <= '0;
              col       <= '0;
              busy      <= 1'b1;
              rd_req    <= 1'b1;
              if (pw_sel) begin
                state   <= ST_NTRAN;
                rpsel   <= RPSEL_BR;
                reg_cmd <= lanes_ntran();
              end else begin
                state   <= ST_INIT_RD;
                rpsel   <= RPSEL_RR;
              end
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        ST_INIT_RD: begin
          if (rd_gnt) begin
            init_cnt <= init_cnt + 2'd1;
            state    <= ST_INIT_WT;
            rd_req   <= 1'b0;
            rpsel    <= RPSEL_NE;
            reg_cmd  <= lanes_all(CMD_IB);
          end
        end

        ST_INIT_WT: begin
          if (pw_q) begin
            // Pointwise: this IB cycle is the whole window.
            col <= col + COL_W'(1);
            if (grp_cnt < nrow_q) begin
              state   <= ST_NTRAN;
              rd_req  <= 1'b1;
              rpsel   <= RPSEL_BR;
              reg_cmd <= lanes_ntran();
            end else begin
              state   <= ST_FLUSH;
              done    <= 1'b1;
              reg_cmd <= lanes_all(CMD_NE);
            end
          end else begin
            state     <= ST_SHIFT;
            shift_cnt <= '0;
            reg_cmd   <= lanes_all(CMD_SF);
          end
        end

        ST_SHIFT: begin
          col <= col + COL_W'(1);
          if (shift_last) begin
            if (init_cnt < stride_q) begin
              state   <= ST_INIT_RD;
              rd_req  <= 1'b1;
              rpsel   <= RPSEL_RR;
              row     <= ROW_W'(init_cnt);
              reg_cmd <= lanes_all(CMD_NE);
            end else if (grp_more) begin
              state   <= ST_NTRAN;
              rd_req  <= 1'b1;
              rpsel   <= RPSEL_BR;
              reg_cmd <= lanes_ntran();
            end else begin
              state   <= ST_FLUSH;
              done    <= 1'b1;
              reg_cmd <= lanes_all(CMD_NE);
            end
          end else begin
            shift_cnt <= shift_cnt + 3'd1;
          end
        end

        ST_NTRAN: begin
          if (rd_gnt) begin
            if (bank == BANK_LAST) begin
              bank <= 2'd0;
              row  <= row + ROW_W'(1);
            end else begin
              bank <= bank + 2'd1;
            end
            grp_cnt <= grp_cnt + ROW_W'(1);
            rd_req  <= 1'b0;
            rpsel   <= RPSEL_NE;
            if (pw_q) begin
              state   <= ST_INIT_WT;
              reg_cmd <= lanes_all(CMD_IB);
            end else begin
              state     <= ST_SHIFT;
              shift_cnt <= '0;
              reg_cmd   <= lanes_all(CMD_SF);
            end
          end
        end

        ST_FLUSH: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          init_cnt  <= '0;
          grp_cnt   <= '0;
          shift_cnt <= '0;
          reg_cmd   <= lanes_all(CMD_NE);
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  wsched_pulse_gen u_pulse_gen (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .pw_mode   (pw_q),
    .pe_ena    (pe_ena),
    .fifo_read (fifo_read)
  );

endmodule

// File: doc/window_sched.md
WINDOW_SCHED -- requirements
Module: window_sched

Interface
REQ-001 SHALL have parameter POY, default 3: number of output-row lanes in the register array.
REQ-002 SHALL have parameter KSIZE_MAX, default 5: largest kernel size accepted at runtime.
REQ-003 SHALL have parameter COL_W, default 28: column address width.
REQ-004 SHALL have parameter ROW_W, default 4: row address and row-count width.
REQ-005 SHALL have ports in this order:
 clk  in  1  sole clock, rising edge.
 rst  in  1  synchronous, active-high reset.
 start  in  1  tile-start pulse from the input buffer.
 cfg_ksize  in  3  kernel size, sampled on an accepted start.
 cfg_stride  in  2  stride (1..POY), sampled on an accepted start.
 cfg_nrow  in  ROW_W  output-row groups per tile (>=1), sampled on an accepted start.
 rd_req  out  1  buffer read request.
 rd_gnt  in  1  buffer grant; a request completes on any cycle where rd_req and rd_gnt are both high.
 rpsel  out  2  read select: RR=0, BR=1, RP=2, NE=3.
 bank  out  2  bank address.
 row  out  ROW_W  row address.
 col  out  COL_W  column address.
 reg_cmd  out  2*POY  per-lane command (IB=0, SF=1, IF=2, NE=3); lane i is bits [2i+1:2i].
 fifo_read  out  1  line-FIFO pop pulse.
 pe_ena  out  1  DWPE enable.
 busy  out  1  tile in progress.
 done  out  1  one-cycle tile-complete pulse.
 cfg_err  out  1  one-cycle illegal-config pulse.

Function
REQ-006 SHALL implement states IDLE, INIT_RD, INIT_WT, SHIFT, NTRAN, FLUSH.
REQ-007 IDLE: on start with legal config (2<=ksize<=KSIZE_MAX, 1<=stride<=POY, nrow>=1), SHALL latch config and go to INIT_RD; on an illegal config, SHALL pulse cfg_err and stay in IDLE.
REQ-008 INIT_RD: SHALL drive rd_req=1, rpsel=RR, row=init_cnt, and hold until grant; on the grant cycle, SHALL increment init_cnt and go to INIT_WT.
REQ-009 INIT_WT: SHALL drive all lanes IB for exactly one cycle, then go to SHIFT.
REQ-010 SHIFT: SHALL last exactly ksize-1 cycles, with all lanes SF, pe_ena=1, and col incremented each cycle modulo 2^COL_W.
REQ-011 At the last SHIFT cycle, the next state SHALL be:
 - INIT_RD if init_cnt<stride;
 - else NTRAN if grp_cnt<nrow-1;
 - else FLUSH.
REQ-012 NTRAN: SHALL drive rd_req=1 and rpsel=BR, and drive lanes 0..POY-2 IF and lane POY-1 IB.
REQ-013 NTRAN: on grant, SHALL advance bank (POY-1 wraps to 0 and increments row), increment grp_cnt, and go to SHIFT.
REQ-014 FLUSH: SHALL pulse done for one cycle, keep pe_ena high for that cycle, and go to IDLE.
REQ-015 fifo_read SHALL pulse for one cycle, two cycles after each SHIFT exit edge.
REQ-016 busy SHALL be high in every state except IDLE; start while busy SHALL be ignored.
REQ-017 While rd_gnt is low, all outputs SHALL hold stable.
REQ-018 Counters SHALL clear on entry to IDLE.

Reset
REQ-019 With rst high at a clock edge, the state SHALL become IDLE regardless of current state, including mid-tile.
REQ-020 Reset values SHALL be:
 - rd_req, pe_ena, fifo_read, busy, done, cfg_err: 0;
 - rpsel=NE, all reg_cmd lanes NE;
 - bank=POY-1, row=0, col=0.

Configuration
REQ-021 With macro WSCHED_PW_EN defined, the block SHALL add input cfg_pw, sampled on start.
REQ-022 With cfg_pw=1, SHALL accept ksize=1 and bypass SHIFT: each NTRAN grant drives all lanes IB, pe_ena=1 for one cycle, and col increments.
REQ-023 Without WSCHED_PW_EN, cfg_pw SHALL be absent and ksize=1 SHALL raise cfg_err.

Structure
REQ-024 The rpsel and reg_cmd encodings and the state enum SHALL be placed in shared package dr_pkg.
REQ-025 The pe_ena/fifo_read delay-line logic SHALL be sub-module wsched_pulse_gen; the FSM and counters SHALL remain in window_sched.

Verification
REQ-026 ksize=3, stride=1, nrow=3, POY=3, rd_gnt tied 1 -> INIT_RD/INIT_WT/SHIFTx2 once, then NTRAN twice; done asserts exactly once; pe_ena high for 6 SHIFT cycles plus the FLUSH cycle.
REQ-027 ksize=5, stride=2, nrow=2 -> two INIT_RD reads with rows 0 and 1, 4-cycle SHIFT windows, one NTRAN with bank 2->0 and row+1.
REQ-028 rd_gnt low for 4 cycles during NTRAN -> rd_req and outputs hold for 4 cycles, with no extra bank advance.
REQ-029 start with cfg_ksize=6 (KSIZE_MAX=5) -> cfg_err pulses once, busy stays 0; start with cfg_stride=0 -> same.
REQ-030 rst asserted during the second SHIFT cycle -> next cycle shows all REQ-020 values; no done pulse; a new start works normally.
REQ-031 WSCHED_PW_EN defined, cfg_pw=1, ksize=1, nrow=4 -> four NTRAN grants, each followed by one pe_ena cycle with all lanes IB, and col ends at 4.
